muxn_pipe_reg: RTL and testbench

Parametrised N-input, WIDTH-bit selector with an integrated pipeline register, stall (hold) and flush (bubble) control, and a valid flag. It is the generalisation of the single-bit 2:1 selector cell. It sits at pipeline-stage boundaries of the CPU (operand forwarding, writeback source select), where a selected value must be registered under hazard control. Latency is one cycle; the registered select and an out-of-range error flag accompany the data.

---
 rtl/mux_pkg.sv | 20 ++
 rtl/muxn_comb.sv | 40 ++++
 rtl/muxn_pipe_reg.sv | 91 +++++++++
 tb/tb_muxn_pipe_reg.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the registered N:1 selector family.
package mux_pkg;

    localparam int DEFAULT_WIDTH = 64;

    // A bubble is an all-zero word; replicate this bit to the needed width.
    localparam logic BUBBLE_BIT = 1'b0;

    // Per-cycle action of the pipeline register.
    typedef enum logic [1:0] {
        ACT_LOAD  = 2'd0,
        ACT_HOLD  = 2'd1,
        ACT_FLUSH = 2'd2
    } pipe_act_e;

    function automatic logic sel_in_range(input int unsigned sel, input int unsigned n);
        return (sel < n);
    endfunction

endpackage

// File: rtl/muxn_comb.sv
// Purely combinational N:1 WIDTH-bit selector built as a binary tree of 2:1 selects.
// Out-of-range selects produce an all-zero word.
module muxn_comb
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic [N*WIDTH-1:0] in,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   d
);

    localparam int LEAVES = 1 << SELW;
    localparam int NODES  = 2 * LEAVES - 1;

    // Heap-ordered tree: node 0 is the root, children of i are 2i+1 (sel bit 0) and 2i+2.
    logic [WIDTH-1:0] node [NODES];

    genvar gi;
    generate
        for (gi = 0; gi < LEAVES; gi++) begin : g_leaf
            if (gi < N) begin : g_real
                assign node[LEAVES-1+gi] = in[gi*WIDTH +: WIDTH];
            end else begin : g_pad
                assign node[LEAVES-1+gi] = {WIDTH{BUBBLE_BIT}};
            end
        end

        for (gi = 0; gi < LEAVES - 1; gi++) begin : g_node
            // The root consumes the MSB of sel; each level down consumes the next bit.
            localparam int DEPTH = $clog2(gi + 2) - 1;
            assign node[gi] = sel[SELW-1-DEPTH] ? node[2*gi+2] : node[2*gi+1];
        end
    endgenerate

    assign d = sel_in_range(32'(sel), $unsigned(N)) ? node[0] : {WIDTH{BUBBLE_BIT}};

endmodule

// File: rtl/muxn_pipe_reg.sv
// N-input selector with a one-cycle pipeline register, stall/flush control,
// a registered valid/select, and a sticky out-of-range select error.
module muxn_pipe_reg
    import mux_pkg::*;
#(
    parameter  int WIDTH = DEFAULT_WIDTH,
    parameter  int N     = 4,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N*WIDTH-1:0] in,
    input  logic [SELW-1:0]    sel,
    input  logic               in_valid,
    input  logic               stall,
    input  logic               flush,
    output logic [WIDTH-1:0]   out,
    output logic               out_valid,
    output logic [SELW-1:0]    out_sel,
    output logic               sel_err
);

    logic [WIDTH-1:0] d;
    pipe_act_e        act;

    logic [WIDTH-1:0] out_reg,       out_next;
    logic             out_valid_reg, out_valid_next;
    logic [SELW-1:0]  out_sel_reg,   out_sel_next;
    logic             sel_err_reg,   sel_err_next;

    muxn_comb #(
        .WIDTH (WIDTH),
        .N     (N)
    ) u_comb (
        .in  (in),
        .sel (sel),
        .d   (d)
    );

    always_comb begin
        act            = ACT_LOAD;
        out_next       = out_reg;
        out_valid_next = out_valid_reg;
        out_sel_next   = out_sel_reg;

        if (flush) begin
            act = ACT_FLUSH;
        end else if (stall) begin
            act = ACT_HOLD;
        end

        case (act)
            ACT_FLUSH: begin
                out_next       = {WIDTH{BUBBLE_BIT}};
                out_valid_next = 1'b0;
                out_sel_next   = '0;
            end
            ACT_LOAD: begin
                // Invalid selections still load; consumers qualify with out_valid.
                out_next       = d;
                out_valid_next = in_valid;
                out_sel_next   = sel;
            end
            default: ;
        endcase

        // Sticky: only a real instruction with a bad select on a load cycle sets it.
        sel_err_next = sel_err_reg
                     | ((act == ACT_LOAD) & in_valid & ~sel_in_range(32'(sel), $unsigned(N)));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_sel_reg   <= '0;
            sel_err_reg   <= 1'b0;
        end else begin
            out_reg       <= out_next;
            out_valid_reg <= out_valid_next;
            out_sel_reg   <= out_sel_next;
            sel_err_reg   <= sel_err_next;
        end
    end

    assign out       = out_reg;
    assign out_valid = out_valid_reg;
    assign out_sel   = out_sel_reg;
    assign sel_err   = sel_err_reg;

endmodule

// File: tb/tb_muxn_pipe_reg.sv
// Self-checking bench: three configurations (N=4/W=64, N=3/W=16, N=5/W=8)
// compared every cycle against a behavioural model of the register rules.
module tb_muxn_pipe_reg;

    localparam int NI = 3;
    localparam int N_OF   [NI] = '{4, 3, 5};
    localparam int W_OF   [NI] = '{64, 16, 8};
    localparam int SMAX_OF[NI] = '{3, 3, 7};

    logic clk;
    logic reset;

    logic [63:0] in_data    [NI][5];
    logic [2:0]  sel_v      [NI];
    logic        in_valid_v [NI];
    logic        stall_v    [NI];
    logic        flush_v    [NI];

    logic [63:0] exp_out    [NI];
    logic [2:0]  exp_sel    [NI];
    logic        exp_valid  [NI];
    logic        exp_err    [NI];

    logic [63:0] out4;
    logic        v4, e4;
    logic [1:0]  s4;
    logic [15:0] out3;
    logic        v3, e3;
    logic [1:0]  s3;
    logic [7:0]  out5;
    logic        v5, e5;
    logic [2:0]  s5;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    muxn_pipe_reg #(.WIDTH(64), .N(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in        ({in_data[0][3], in_data[0][2], in_data[0][1], in_data[0][0]}),
        .sel       (sel_v[0][1:0]),
        .in_valid  (in_valid_v[0]),
        .stall     (stall_v[0]),
        .flush     (flush_v[0]),
        .out       (out4),
        .out_valid (v4),
        .out_sel   (s4),
        .sel_err   (e4)
    );

    muxn_pipe_reg #(.WIDTH(16), .N(3)) dut3 (
        .clk       (clk),
        .reset     (reset),
        .in        ({in_data[1][2][15:0], in_data[1][1][15:0], in_data[1][0][15:0]}),
        .sel       (sel_v[1][1:0]),
        .in_valid  (in_valid_v[1]),
        .stall     (stall_v[1]),
        .flush     (flush_v[1]),
        .out       (out3),
        .out_valid (v3),
        .out_sel   (s3),
        .sel_err   (e3)
    );

    muxn_pipe_reg #(.WIDTH(8), .N(5)) dut5 (
        .clk       (clk),
        .reset     (reset),
        .in        ({in_data[2][4][7:0], in_data[2][3][7:0], in_data[2][2][7:0],
                     in_data[2][1][7:0], in_data[2][0][7:0]}),
        .sel       (sel_v[2]),
        .in_valid  (in_valid_v[2]),
        .stall     (stall_v[2]),
        .flush     (flush_v[2]),
        .out       (out5),
        .out_valid (v5),
        .out_sel   (s5),
        .sel_err   (e5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got 0x%0h, expected 0x%0h", tag, cycle, got, exp);
        end
    endtask

    function automatic logic [63:0] wmask(input int i);
        return (W_OF[i] == 64) ? {64{1'b1}} : ((64'd1 << W_OF[i]) - 64'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            exp_out[i]   = '0;
            exp_valid[i] = 1'b0;
            exp_sel[i]   = '0;
            exp_err[i]   = 1'b0;
        end
    endtask

    // Register rules: flush gives a bubble, stall holds, otherwise load in[sel] (0 if out of range).
    task automatic model_edge();
        for (int i = 0; i < NI; i++) begin
            if (flush_v[i]) begin
                exp_out[i]   = '0;
                exp_valid[i] = 1'b0;
                exp_sel[i]   = '0;
            end else if (!stall_v[i]) begin
                if (int'(sel_v[i]) < N_OF[i]) exp_out[i] = in_data[i][sel_v[i]] & wmask(i);
                else                          exp_out[i] = '0;
                exp_valid[i] = in_valid_v[i];
                exp_sel[i]   = sel_v[i];
                if (in_valid_v[i] && int'(sel_v[i]) >= N_OF[i]) exp_err[i] = 1'b1;
            end
        end
    endtask

    task automatic check_all(input string what);
        check({what, " n4.out"},   out4,              exp_out[0]);
        check({what, " n4.valid"}, {63'd0, v4},       {63'd0, exp_valid[0]});
        check({what, " n4.sel"},   {62'd0, s4},       {61'd0, exp_sel[0]});
        check({what, " n4.err"},   {63'd0, e4},       {63'd0, exp_err[0]});
        check({what, " n3.out"},   {48'd0, out3},     exp_out[1]);
        check({what, " n3.valid"}, {63'd0, v3},       {63'd0, exp_valid[1]});
        check({what, " n3.sel"},   {62'd0, s3},       {61'd0, exp_sel[1]});
        check({what, " n3.err"},   {63'd0, e3},       {63'd0, exp_err[1]});
        check({what, " n5.out"},   {56'd0, out5},     exp_out[2]);
        check({what, " n5.valid"}, {63'd0, v5},       {63'd0, exp_valid[2]});
        check({what, " n5.sel"},   {61'd0, s5},       {61'd0, exp_sel[2]});
        check({what, " n5.err"},   {63'd0, e5},       {63'd0, exp_err[2]});
    endtask

    // Advance one clock edge with the inputs currently driven, then compare.
    task automatic step(input string what);
        if (reset) model_reset();
        else       model_edge();
        @(posedge clk);
        #1;
        cycle++;
        check_all(what);
        $display("[%0d] %s n4=%0h/%0b n3=%0h/%0b/err%0b n5=%0h/%0b", cycle, what,
                 out4, v4, out3, v3, e3, out5, v5);
    endtask

    task automatic idle_all();
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 5; k++) in_data[i][k] = '0;
            sel_v[i]      = '0;
            in_valid_v[i] = 1'b0;
            stall_v[i]    = 1'b0;
            flush_v[i]    = 1'b0;
        end
    endtask

    task automatic rand_inputs(input int i);
        for (int k = 0; k < 5; k++) in_data[i][k] = {$urandom, $urandom} & wmask(i);
        sel_v[i]      = 3'($urandom_range(SMAX_OF[i], 0));
        in_valid_v[i] = 1'($urandom_range(1, 0));
        stall_v[i]    = ($urandom_range(3, 0) == 0);
        flush_v[i]    = ($urandom_range(9, 0) == 0);
    endtask

    initial begin
        idle_all();
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_all("reset");
        reset = 1'b0;

        // Basic load on the 4-input instance.
        in_data[0][2] = 64'h1234; sel_v[0] = 3'd2; in_valid_v[0] = 1'b1;
        step("basic");

        // Asynchronous reset mid-cycle with 0xDEAD held in the register.
        in_data[0][1] = 64'hDEAD; sel_v[0] = 3'd1;
        step("load_dead");
        #3 reset = 1'b1;
        #1 model_reset();
        check_all("async_reset");
        #1 reset = 1'b0;

        // Stall for three cycles while inputs change.
        in_data[0][0] = 64'hAAAA; sel_v[0] = 3'd0; in_valid_v[0] = 1'b1;
        step("load_aaaa");
        stall_v[0] = 1'b1;
        for (int c = 0; c < 3; c++) begin
            for (int k = 0; k < 4; k++) in_data[0][k] = {$urandom, $urandom};
            sel_v[0] = 3'($urandom_range(3, 0));
            step("stall");
        end
        stall_v[0] = 1'b0;
        step("stall_release");

        // Flush overrides stall while a valid word is selected.
        in_data[0][3] = 64'h5555; sel_v[0] = 3'd3; in_valid_v[0] = 1'b1;
        stall_v[0] = 1'b1; flush_v[0] = 1'b1;
        step("flush_stall");
        stall_v[0] = 1'b0; flush_v[0] = 1'b0;
        step("after_flush");

        // Out-of-range select on N=3: invalid first (no error), then valid (sticky error).
        in_data[1][0] = 64'h0BAD; in_data[1][1] = 64'h1111; in_data[1][2] = 64'h2222;
        sel_v[1] = 3'd3; in_valid_v[1] = 1'b0;
        step("oor_invalid");
        in_valid_v[1] = 1'b1;
        step("oor_valid");
        sel_v[1] = 3'd1;
        step("oor_then_load");
        flush_v[1] = 1'b1;
        step("oor_then_flush");
        flush_v[1] = 1'b0; sel_v[1] = 3'd2;
        stall_v[1] = 1'b1;
        step("oor_stall");
        // Reset in the middle of a stall clears everything including the sticky error.
        #3 reset = 1'b1;
        #1 model_reset();
        check_all("reset_mid_stall");
        #1 reset = 1'b0;
        stall_v[1] = 1'b0;
        step("after_reset");

        // Sweep all five inputs on N=5.
        for (int k = 0; k < 5; k++) in_data[2][k] = 64'(8'h10 + k);
        in_valid_v[2] = 1'b1;
        for (int s = 0; s < 5; s++) begin
            sel_v[2] = 3'(s);
            step("sweep");
        end

        // Randomised traffic on all instances, with one asynchronous reset pulse.
        for (int c = 0; c < 200; c++) begin
            for (int i = 0; i < NI; i++) rand_inputs(i);
            if (c == 120) begin
                #2 reset = 1'b1;
                #1 model_reset();
                check_all("rand_reset");
                #1 reset = 1'b0;
            end
            step("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
